machine_trap_sequencer: RTL and testbench

//  Controller for machine-mode trap entry and MRET return in the RV32 core. It arbitrates synchronous

---
 rtl/machine_trap_sequencer_pkg.sv | 37 +++
 rtl/machine_trap_sequencer_if.sv | 41 ++++
 rtl/machine_trap_sequencer_irq_prio_enc.sv | 34 +++
 rtl/machine_trap_sequencer.sv | 122 ++++++++++++
 tb/tb_machine_trap_sequencer.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/machine_trap_sequencer_pkg.sv
// Shared machine-mode CSR definitions: addresses, interrupt cause codes,
// mtvec mode encoding, the trap FSM states and the trap-vector helper.
package machine_trap_sequencer_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [3:0] CAUSE_MSI = 4'd3;
  localparam logic [3:0] CAUSE_MTI = 4'd7;
  localparam logic [3:0] CAUSE_MEI = 4'd11;

  typedef enum logic [1:0] {
    MTVEC_DIRECT   = 2'd0,
    MTVEC_VECTORED = 2'd1
  } mtvec_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_TRAP_SAVE = 2'd1,
    ST_TRAP_VEC  = 2'd2,
    ST_MRET_RET  = 2'd3
  } trap_state_e;

  // Modes 2 and 3 fall through to direct; the vectored add wraps at 32 bits.
  function automatic logic [31:0] trap_vector(input logic [31:0] mtvec,
                                              input logic        is_irq,
                                              input logic [3:0]  code);
    logic [31:0] base;
    base = {mtvec[31:2], 2'b00};
    if (is_irq && (mtvec[1:0] == MTVEC_VECTORED))
      return base + {26'b0, code, 2'b00};
    return base;
  endfunction

endpackage

// File: rtl/machine_trap_sequencer_if.sv
// Execute-stage / CSR-file side of the trap sequencer. The master drives the
// events and CSR views; the slave (the sequencer) drives strobes and redirect.
interface machine_trap_sequencer_if;
  logic        exception_in;
  logic [3:0]  exc_cause_in;
  logic        mret_in;
  logic        meip_in, mtip_in, msip_in;
  logic        meie_in, mtie_in, msie_in;
  logic [31:0] pc_in;
  logic [31:0] mtvec_in;
  logic [31:0] epc_in;
  logic        wr_en_in;
  logic [11:0] csr_addr_in;
  logic [31:0] data_wr_in;

  logic        set_epc_out;
  logic        set_cause_out;
  logic [31:0] cause_out;
  logic        mstatus_mie_out;
  logic        mstatus_mpie_out;
  logic        pc_redirect_out;
  logic [31:0] redirect_pc_out;
  logic        stall_out;
  logic        trap_taken_out;

  modport master (
    output exception_in, exc_cause_in, mret_in,
           meip_in, mtip_in, msip_in, meie_in, mtie_in, msie_in,
           pc_in, mtvec_in, epc_in, wr_en_in, csr_addr_in, data_wr_in,
    input  set_epc_out, set_cause_out, cause_out, mstatus_mie_out, mstatus_mpie_out,
           pc_redirect_out, redirect_pc_out, stall_out, trap_taken_out
  );

  modport slave (
    input  exception_in, exc_cause_in, mret_in,
           meip_in, mtip_in, msip_in, meie_in, mtie_in, msie_in,
           pc_in, mtvec_in, epc_in, wr_en_in, csr_addr_in, data_wr_in,
    output set_epc_out, set_cause_out, cause_out, mstatus_mie_out, mstatus_mpie_out,
           pc_redirect_out, redirect_pc_out, stall_out, trap_taken_out
  );
endinterface

// File: rtl/machine_trap_sequencer_irq_prio_enc.sv
// Combinational interrupt eligibility and cause-code selection,
// priority MEI > MSI > MTI, all gated by mstatus.MIE.
module machine_trap_sequencer_irq_prio_enc
  import machine_trap_sequencer_pkg::*;
(
  input  logic       mie_i,
  input  logic       meip_i,
  input  logic       meie_i,
  input  logic       msip_i,
  input  logic       msie_i,
  input  logic       mtip_i,
  input  logic       mtie_i,
  output logic       irq_o,
  output logic [3:0] code_o
);

  always_comb begin
    irq_o  = 1'b0;
    code_o = 4'd0;
    if (mie_i) begin
      if (meip_i && meie_i) begin
        irq_o  = 1'b1;
        code_o = CAUSE_MEI;
      end else if (msip_i && msie_i) begin
        irq_o  = 1'b1;
        code_o = CAUSE_MSI;
      end else if (mtip_i && mtie_i) begin
        irq_o  = 1'b1;
        code_o = CAUSE_MTI;
      end
    end
  end

endmodule

// File: rtl/machine_trap_sequencer.sv
// Machine-mode trap entry / MRET sequencer: arbitrates exceptions, interrupts
// and MRET, strobes mepc/mcause updates, owns MIE/MPIE and redirects fetch.
module machine_trap_sequencer
  import machine_trap_sequencer_pkg::*;
#(
  parameter logic [11:0] MSTATUS    = CSR_MSTATUS,
  parameter logic        MIE_RESET  = 1'b0,
  parameter logic        MPIE_RESET = 1'b0
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  machine_trap_sequencer_if.slave  bus
);

  trap_state_e state_q, state_d;
  logic [31:0] cause_q, cause_d;
  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic        stall_q;

  logic        irq;
  logic [3:0]  irq_code;
  logic        csr_wr;
  logic        set_epc, set_cause, trap_taken, pc_redirect;
  logic [31:0] redirect_pc;

  machine_trap_sequencer_irq_prio_enc u_prio (
    .mie_i  (mie_q),
    .meip_i (bus.meip_in),
    .meie_i (bus.meie_in),
    .msip_i (bus.msip_in),
    .msie_i (bus.msie_in),
    .mtip_i (bus.mtip_in),
    .mtie_i (bus.mtie_in),
    .irq_o  (irq),
    .code_o (irq_code)
  );

  assign csr_wr = bus.wr_en_in && (bus.csr_addr_in == MSTATUS);

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    mie_d       = mie_q;
    mpie_d      = mpie_q;
    set_epc     = 1'b0;
    set_cause   = 1'b0;
    trap_taken  = 1'b0;
    pc_redirect = 1'b0;
    redirect_pc = 32'h0;
    case (state_q)
      ST_IDLE: begin
        // Acceptance of any event swallows a coincident mstatus write.
        if (bus.exception_in) begin
          state_d = ST_TRAP_SAVE;
          cause_d = {1'b0, 27'b0, bus.exc_cause_in};
        end else if (irq) begin
          state_d = ST_TRAP_SAVE;
          cause_d = {1'b1, 27'b0, irq_code};
        end else if (bus.mret_in) begin
          state_d = ST_MRET_RET;
        end else if (csr_wr) begin
          mie_d  = bus.data_wr_in[3];
          mpie_d = bus.data_wr_in[7];
        end
      end
      ST_TRAP_SAVE: begin
        // mepc loads pc_in directly; the stall holds pc_in stable here.
        set_epc    = 1'b1;
        set_cause  = 1'b1;
        trap_taken = 1'b1;
        mpie_d     = mie_q;
        mie_d      = 1'b0;
        state_d    = ST_TRAP_VEC;
      end
      ST_TRAP_VEC: begin
        pc_redirect = 1'b1;
        redirect_pc = trap_vector(bus.mtvec_in, cause_q[31], cause_q[3:0]);
        state_d     = ST_IDLE;
      end
      ST_MRET_RET: begin
        pc_redirect = 1'b1;
        redirect_pc = {bus.epc_in[31:2], 2'b00};
        mie_d       = mpie_q;
        mpie_d      = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= ST_IDLE;
      cause_q <= 32'h0;
      mie_q   <= MIE_RESET;
      mpie_q  <= MPIE_RESET;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      mie_q   <= mie_d;
      mpie_q  <= mpie_d;
      stall_q <= (state_d != ST_IDLE);
    end
  end

  assign bus.set_epc_out      = set_epc;
  assign bus.set_cause_out    = set_cause;
  assign bus.trap_taken_out   = trap_taken;
  assign bus.pc_redirect_out  = pc_redirect;
  assign bus.redirect_pc_out  = redirect_pc;
  assign bus.cause_out        = cause_q;
  assign bus.mstatus_mie_out  = mie_q;
  assign bus.mstatus_mpie_out = mpie_q;
  assign bus.stall_out        = stall_q;

  logic unused_ok;
  assign unused_ok = ^{bus.pc_in, bus.epc_in[1:0], bus.data_wr_in[31:8],
                       bus.data_wr_in[6:4], bus.data_wr_in[2:0], cause_q[30:4]};

endmodule

// File: tb/tb_machine_trap_sequencer.sv
// Directed bench for machine_trap_sequencer with an expected-result scoreboard.
module tb_machine_trap_sequencer;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  int   tests  = 0;
  int   fails  = 0;

  logic [31:0] exp_cause_q[$];
  logic [31:0] exp_redir_q[$];

  always #5 clk_in = ~clk_in;

  machine_trap_sequencer_if bus();

  machine_trap_sequencer dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus.slave)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_sig(input string tag, input bit want_redirect);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (want_redirect ? bus.pc_redirect_out : bus.set_epc_out) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tests++;
    assert (ok) else begin
      fails++;
      $error("FAIL %s timeout observed=no_strobe expected=strobe", tag);
    end
  endtask

  task automatic pop_cause(input string tag);
    logic [31:0] e;
    e = (exp_cause_q.size() != 0) ? exp_cause_q.pop_front() : 32'hDEAD_BEEF;
    check(tag, bus.cause_out, e);
  endtask

  task automatic pop_redir(input string tag);
    logic [31:0] e;
    e = (exp_redir_q.size() != 0) ? exp_redir_q.pop_front() : 32'hDEAD_BEEF;
    check(tag, bus.redirect_pc_out, e);
  endtask

  task automatic expect_trap(input string tag);
    wait_sig({tag, "_epc"}, 1'b0);
    pop_cause({tag, "_cause"});
    check({tag, "_setcause"}, bus.set_cause_out, 1);
    check({tag, "_taken"}, bus.trap_taken_out, 1);
    check({tag, "_stall"}, bus.stall_out, 1);
    tick();
    wait_sig({tag, "_redir"}, 1'b1);
    pop_redir({tag, "_pc"});
    check({tag, "_noepc"}, bus.set_epc_out, 0);
    tick();
    check({tag, "_idle"}, bus.stall_out, 0);
  endtask

  task automatic csr_write(input logic [31:0] data);
    bus.wr_en_in    = 1'b1;
    bus.csr_addr_in = 12'h300;
    bus.data_wr_in  = data;
    tick();
    bus.wr_en_in    = 1'b0;
  endtask

  initial begin
    bus.exception_in = 0; bus.exc_cause_in = 0; bus.mret_in = 0;
    bus.meip_in = 0; bus.mtip_in = 0; bus.msip_in = 0;
    bus.meie_in = 0; bus.mtie_in = 0; bus.msie_in = 0;
    bus.pc_in = 0; bus.mtvec_in = 0; bus.epc_in = 0;
    bus.wr_en_in = 0; bus.csr_addr_in = 0; bus.data_wr_in = 0;

    // Reset
    rst_in = 1'b0;
    tick(); tick();
    check("rst_stall", bus.stall_out, 0);
    check("rst_cause", bus.cause_out, 0);
    check("rst_redir_pc", bus.redirect_pc_out, 0);
    check("rst_strobes", {bus.set_epc_out, bus.set_cause_out, bus.pc_redirect_out, bus.trap_taken_out}, 0);
    check("rst_mstatus", {bus.mstatus_mpie_out, bus.mstatus_mie_out}, 0);
    rst_in = 1'b1;

    // Exception with MIE=1
    csr_write(32'h08);
    check("wr_mie", {bus.mstatus_mpie_out, bus.mstatus_mie_out}, 2'b01);
    bus.pc_in = 32'h100; bus.mtvec_in = 32'h800;
    bus.exception_in = 1; bus.exc_cause_in = 4'd2;
    exp_cause_q.push_back(32'h2); exp_redir_q.push_back(32'h800);
    tick();
    bus.exception_in = 0;
    expect_trap("exc");
    check("exc_mstatus", {bus.mstatus_mpie_out, bus.mstatus_mie_out}, 2'b10);

    // Vectored timer interrupt
    csr_write(32'h08);
    bus.mtip_in = 1; bus.mtie_in = 1; bus.mtvec_in = 32'h1001;
    exp_cause_q.push_back(32'h8000_0007); exp_redir_q.push_back(32'h101C);
    tick();
    bus.mtip_in = 0; bus.mtie_in = 0;
    expect_trap("mti_vec");
    check("mti_mstatus", {bus.mstatus_mpie_out, bus.mstatus_mie_out}, 2'b10);

    // Exception beats interrupt and MRET
    csr_write(32'h08);
    bus.exception_in = 1; bus.exc_cause_in = 4'd5; bus.mret_in = 1;
    bus.meip_in = 1; bus.meie_in = 1; bus.mtvec_in = 32'h800;
    exp_cause_q.push_back(32'h5); exp_redir_q.push_back(32'h800);
    tick();
    bus.exception_in = 0; bus.mret_in = 0;
    expect_trap("prio_exc");

    // All three interrupts pending: MEI wins, enabled the cycle after the write
    bus.msip_in = 1; bus.msie_in = 1; bus.mtip_in = 1; bus.mtie_in = 1;
    exp_cause_q.push_back(32'h8000_000B); exp_redir_q.push_back(32'h800);
    csr_write(32'h08);
    check("irq_wait_cycle", bus.stall_out, 0);
    expect_trap("prio_mei");
    bus.msip_in = 0; bus.msie_in = 0; bus.mtip_in = 0; bus.mtie_in = 0;

    // Vectored MEI with wraparound past 2^32
    csr_write(32'h08);
    bus.mtvec_in = 32'hFFFF_FFFD;
    exp_cause_q.push_back(32'h8000_000B); exp_redir_q.push_back(32'h0000_0028);
    tick();
    bus.meip_in = 0; bus.meie_in = 0;
    expect_trap("vec_wrap");

    // Exceptions ignore vectored mode; MPIE takes MIE=0
    bus.mtvec_in = 32'h1001; bus.exception_in = 1; bus.exc_cause_in = 4'd15;
    exp_cause_q.push_back(32'hF); exp_redir_q.push_back(32'h1000);
    tick();
    bus.exception_in = 0;
    expect_trap("exc_vecmode");
    check("exc_mie0_mstatus", {bus.mstatus_mpie_out, bus.mstatus_mie_out}, 2'b00);

    // MRET: MPIE=1, MIE=0
    csr_write(32'h80);
    check("mret_pre", {bus.mstatus_mpie_out, bus.mstatus_mie_out}, 2'b10);
    bus.epc_in = 32'h203; bus.mret_in = 1;
    exp_redir_q.push_back(32'h200);
    tick();
    bus.mret_in = 0;
    wait_sig("mret_redir", 1'b1);
    pop_redir("mret_pc");
    check("mret_stall", bus.stall_out, 1);
    check("mret_noepc", bus.set_epc_out, 0);
    tick();
    check("mret_mstatus", {bus.mstatus_mpie_out, bus.mstatus_mie_out}, 2'b11);
    check("mret_idle", bus.stall_out, 0);

    // MRET with MPIE=0
    csr_write(32'h08);
    bus.epc_in = 32'h1000_0007; bus.mret_in = 1;
    exp_redir_q.push_back(32'h1000_0004);
    tick();
    bus.mret_in = 0;
    wait_sig("mret2_redir", 1'b1);
    pop_redir("mret2_pc");
    tick();
    check("mret2_mstatus", {bus.mstatus_mpie_out, bus.mstatus_mie_out}, 2'b10);

    // Reset during TRAP_SAVE
    bus.mtvec_in = 32'h800; bus.pc_in = 32'h100;
    bus.exception_in = 1; bus.exc_cause_in = 4'd2;
    exp_cause_q.push_back(32'h2);
    tick();
    bus.exception_in = 0;
    wait_sig("rstmid_epc", 1'b0);
    pop_cause("rstmid_cause");
    rst_in = 1'b0;
    tick();
    check("rstmid_strobes", {bus.set_epc_out, bus.set_cause_out, bus.pc_redirect_out, bus.trap_taken_out}, 0);
    check("rstmid_stall", bus.stall_out, 0);
    check("rstmid_cause0", bus.cause_out, 0);
    check("rstmid_redir_pc", bus.redirect_pc_out, 0);
    check("rstmid_mstatus", {bus.mstatus_mpie_out, bus.mstatus_mie_out}, 2'b00);
    rst_in = 1'b1;
    tick();
    check("rstmid_after", {bus.set_epc_out, bus.pc_redirect_out, bus.stall_out}, 0);

    // mstatus write coinciding with trap acceptance is dropped
    bus.exception_in = 1; bus.exc_cause_in = 4'd4;
    bus.wr_en_in = 1; bus.csr_addr_in = 12'h300; bus.data_wr_in = 32'h08;
    exp_cause_q.push_back(32'h4); exp_redir_q.push_back(32'h800);
    tick();
    bus.exception_in = 0; bus.wr_en_in = 0;
    expect_trap("wr_coinc");
    check("wr_coinc_mstatus", {bus.mstatus_mpie_out, bus.mstatus_mie_out}, 2'b00);

    // mstatus write while stalled is ignored
    bus.exception_in = 1; bus.exc_cause_in = 4'd6;
    exp_cause_q.push_back(32'h6); exp_redir_q.push_back(32'h800);
    tick();
    bus.exception_in = 0;
    bus.wr_en_in = 1; bus.csr_addr_in = 12'h300; bus.data_wr_in = 32'h88;
    expect_trap("wr_stall");
    bus.wr_en_in = 0;
    check("wr_stall_mstatus", {bus.mstatus_mpie_out, bus.mstatus_mie_out}, 2'b00);

    check("sb_cause_empty", exp_cause_q.size(), 0);
    check("sb_redir_empty", exp_redir_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
